// File: rtl/param_deserializer.sv
// Serial-to-parallel frame receiver: captures DATA_WIDTH strobed bits in either
// bit order, optionally checks a trailing parity bit, and presents the word for one cycle.
module param_deserializer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  deser_en,
   input  logic                  bit_strb,
   input  logic                  sampled_bit,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  MSB_FIRST,
   input  logic                  frm_clr,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  busy,
   output logic [CNT_W-1:0]      bit_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

   state_t                  state_reg, state_next;
   logic [DATA_WIDTH-1:0]   word_reg, word_next, word_base;
   logic [DATA_WIDTH-1:0]   p_data_reg, p_data_next;
   logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
   logic [CNT_W-1:0]        cap_idx;
   logic                    cap_en;
   logic                    par_en_reg, par_en_next;
   logic                    par_typ_reg, par_typ_next;
   logic                    msb_first_reg, msb_first_next;
   logic                    data_valid_reg, data_valid_next;
   logic                    par_err_reg, par_err_next;

   // Working word = base value with at most one bit overwritten by the current capture.
   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_capture
         assign word_next[gi] = (cap_en && (cap_idx == CNT_W'(gi))) ? sampled_bit : word_base[gi];
      end
   endgenerate

   assign p_data_next = data_valid_next ? word_next : p_data_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         word_reg       <= '0;
         p_data_reg     <= '0;
         bit_cnt_reg    <= '0;
         par_en_reg     <= 1'b0;
         par_typ_reg    <= 1'b0;
         msb_first_reg  <= 1'b0;
         data_valid_reg <= 1'b0;
         par_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         word_reg       <= word_next;
         p_data_reg     <= p_data_next;
         bit_cnt_reg    <= bit_cnt_next;
         par_en_reg     <= par_en_next;
         par_typ_reg    <= par_typ_next;
         msb_first_reg  <= msb_first_next;
         data_valid_reg <= data_valid_next;
         par_err_reg    <= par_err_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      word_base       = word_reg;
      bit_cnt_next    = bit_cnt_reg;
      cap_en          = 1'b0;
      cap_idx         = '0;
      par_en_next     = par_en_reg;
      par_typ_next    = par_typ_reg;
      msb_first_next  = msb_first_reg;
      data_valid_next = 1'b0;
      par_err_next    = par_err_reg;

      if (frm_clr) begin
         state_next   = IDLE;
         bit_cnt_next = '0;
         word_base    = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               // DATA_WIDTH >= 2, so the first capture can never complete the word.
               if (deser_en && bit_strb) begin
                  word_base      = '0;
                  cap_en         = 1'b1;
                  cap_idx        = MSB_FIRST ? LAST_IDX : '0;
                  bit_cnt_next   = CNT_W'(1);
                  par_en_next    = PAR_EN;
                  par_typ_next   = PAR_TYP;
                  msb_first_next = MSB_FIRST;
                  state_next     = SHIFT;
               end
            end
            SHIFT: begin
               if (!deser_en) begin
                  state_next   = IDLE;
                  bit_cnt_next = '0;
                  word_base    = '0;
               end else if (bit_strb) begin
                  cap_en       = 1'b1;
                  cap_idx      = msb_first_reg ? (LAST_IDX - bit_cnt_reg) : bit_cnt_reg;
                  bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                  if (bit_cnt_reg == LAST_IDX) begin
                     if (par_en_reg) begin
                        state_next = PARITY;
                     end else begin
                        state_next      = DONE;
                        data_valid_next = 1'b1;
                        par_err_next    = 1'b0;
                     end
                  end
               end
            end
            PARITY: begin
               if (!deser_en) begin
                  state_next   = IDLE;
                  bit_cnt_next = '0;
                  word_base    = '0;
               end else if (bit_strb) begin
                  state_next      = DONE;
                  data_valid_next = 1'b1;
                  par_err_next    = ((^word_reg) ^ par_typ_reg) != sampled_bit;
               end
            end
            DONE: begin
               state_next   = IDLE;
               bit_cnt_next = '0;
               word_base    = '0;
            end
            default: begin
               state_next   = IDLE;
               bit_cnt_next = '0;
               word_base    = '0;
            end
         endcase
      end
   end

   assign P_DATA     = p_data_reg;
   assign data_valid = data_valid_reg;
   assign par_err    = par_err_reg;
   assign busy       = (state_reg != IDLE);
   assign bit_cnt    = bit_cnt_reg;

endmodule
